// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state/class enums and default opcode map for multicycle_ctrl_fsm.
package ctrl_pkg;
   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC, S_ERR} state_t;
   typedef enum logic [2:0] {CLS_R, CLS_I, CLS_BR, CLS_JMP, CLS_ILL} cls_t;
   localparam int DEF_OPCODE_W    = 4;
   localparam int DEF_R_LAST      = 8;
   localparam int DEF_I_LAST      = 11;
   localparam int DEF_BR_LAST     = 14;
   localparam int DEF_JUMP_OP     = 15;
   localparam int DEF_MEM_TIMEOUT = 16;
   localparam int DEF_CNT_W       = 32;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps an opcode onto R/I/branch/jump/illegal using contiguous range limits.
module opcode_classifier import ctrl_pkg::*; #(
   parameter int OPCODE_W = DEF_OPCODE_W,
   parameter int R_LAST   = DEF_R_LAST,
   parameter int I_LAST   = DEF_I_LAST,
   parameter int BR_LAST  = DEF_BR_LAST,
   parameter int JUMP_OP  = DEF_JUMP_OP
) (
   input  logic [OPCODE_W-1:0] opcode,
   output cls_t                cls
);
   localparam logic [OPCODE_W-1:0] R_L = OPCODE_W'(R_LAST);
   localparam logic [OPCODE_W-1:0] I_L = OPCODE_W'(I_LAST);
   localparam logic [OPCODE_W-1:0] B_L = OPCODE_W'(BR_LAST);
   localparam logic [OPCODE_W-1:0] J_O = OPCODE_W'(JUMP_OP);
   assign cls = opcode <= R_L ? CLS_R :
                opcode <= I_L ? CLS_I :
                opcode <= B_L ? CLS_BR :
                opcode == J_O ? CLS_JMP : CLS_ILL;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: sequences DECODE/EXEC/MEM/WB/PC per accepted opcode with memory timeout.
// Define PERF_CNT_EN to build the retired-instruction counter; otherwise retired_cnt is tied to 0.
module multicycle_ctrl_fsm import ctrl_pkg::*; #(
   parameter int OPCODE_W    = DEF_OPCODE_W,
   parameter int R_LAST      = DEF_R_LAST,
   parameter int I_LAST      = DEF_I_LAST,
   parameter int BR_LAST     = DEF_BR_LAST,
   parameter int JUMP_OP     = DEF_JUMP_OP,
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ack,
   output logic                mem_req,
   output logic                alu_en,
   output logic                immediate_en,
   output logic                branch_en,
   output logic                jump_en,
   output logic                write_en,
   output logic                pc_load,
   output logic                busy,
   output logic                err_pulse,
   output logic [CNT_W-1:0]    retired_cnt
);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);
   state_t state, state_nx;
   logic [OPCODE_W-1:0] op_q;
   logic [TW-1:0] tmo_q;
   cls_t cls;
   opcode_classifier #(
      .OPCODE_W(OPCODE_W), .R_LAST(R_LAST), .I_LAST(I_LAST),
      .BR_LAST(BR_LAST), .JUMP_OP(JUMP_OP)
   ) u_cls (
      .opcode(op_q),
      .cls(cls)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         op_q  <= '0;
         tmo_q <= '0;
      end else begin
         state <= state_nx;
         if (instr_valid && instr_ready) op_q <= opcode;
         tmo_q <= state == S_MEM ? tmo_q + 1'b1 : '0;
      end
   end
   // an ack on the final allowed MEM cycle still wins over the timeout
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = instr_valid ? S_DECODE : S_IDLE;
         S_DECODE: state_nx = cls == CLS_ILL ? S_ERR : S_EXEC;
         S_EXEC:   state_nx = cls == CLS_R ? S_WB : cls == CLS_I ? S_MEM : S_PC;
         S_MEM:    state_nx = mem_ack ? S_WB : tmo_q == TMO_LAST ? S_ERR : S_MEM;
         default:  state_nx = S_IDLE;
      endcase
   end
   assign instr_ready  = state == S_IDLE;
   assign busy         = !instr_ready;
   assign alu_en       = state == S_EXEC;
   assign mem_req      = state == S_MEM;
   assign write_en     = state == S_WB;
   assign pc_load      = state == S_PC;
   assign err_pulse    = state == S_ERR;
   assign immediate_en = busy && cls == CLS_I;
   assign branch_en    = busy && cls == CLS_BR;
   assign jump_en      = busy && cls == CLS_JMP;
`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else if (state == S_WB || state == S_PC) cnt_q <= cnt_q + 1'b1;
   end
   assign retired_cnt = cnt_q;
`else
   assign retired_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed + random check of two configurations against a latency-rule model.
module tb_multicycle_ctrl_fsm;
   logic clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, mem_ack = 1'b0;
   logic [3:0] opcode = 4'd0;
   wire [9:0] dv0, dv1;
   wire [31:0] rc0, rc1;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   multicycle_ctrl_fsm dut0 (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(dv0[9]),
      .opcode(opcode), .mem_ack(mem_ack), .mem_req(dv0[3]), .alu_en(dv0[7]),
      .immediate_en(dv0[6]), .branch_en(dv0[5]), .jump_en(dv0[4]), .write_en(dv0[2]),
      .pc_load(dv0[1]), .busy(dv0[8]), .err_pulse(dv0[0]), .retired_cnt(rc0)
   );
   multicycle_ctrl_fsm #(.BR_LAST(13), .JUMP_OP(14), .MEM_TIMEOUT(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(dv1[9]),
      .opcode(opcode), .mem_ack(mem_ack), .mem_req(dv1[3]), .alu_en(dv1[7]),
      .immediate_en(dv1[6]), .branch_en(dv1[5]), .jump_en(dv1[4]), .write_en(dv1[2]),
      .pc_load(dv1[1]), .busy(dv1[8]), .err_pulse(dv1[0]), .retired_cnt(rc1)
   );
   // model: class 0=R 1=I 2=branch 3=jump 4=illegal; k counts cycles since the accept edge
   localparam int RL = 8, IL = 11;
   localparam int BLV [2] = '{14, 13};
   localparam int JOV [2] = '{15, 14};
   localparam int TOV [2] = '{16, 4};
   bit m_on = 1'b0;
   bit m_busy [2] = '{1'b0, 1'b0};
   int m_k [2] = '{0, 0};
   int m_cls [2] = '{0, 0};
   int m_ack [2] = '{0, 0};
   logic [31:0] m_ret [2] = '{32'd0, 32'd0};
   function automatic int cls_of(input int i, input int op);
      return op <= RL ? 0 : op <= IL ? 1 : op <= BLV[i] ? 2 : op == JOV[i] ? 3 : 4;
   endfunction
   function automatic int last_cyc(input int i);
      return m_cls[i] == 4 ? 2 : m_cls[i] != 1 ? 3 : m_ack[i] != 0 ? m_ack[i] + 1 : 3 + TOV[i];
   endfunction
   function automatic logic [9:0] exp_vec(input int i);
      bit b = m_busy[i];
      int k = m_k[i];
      int c = m_cls[i];
      bit acked = m_ack[i] != 0;
      bit fin = b && k == last_cyc(i);
      return {!b, b, b && k == 2 && c != 4, b && c == 1, b && c == 2, b && c == 3,
              b && c == 1 && !acked && k >= 3 && k <= 2 + TOV[i],
              fin && (c == 0 || (c == 1 && acked)),
              b && k == 3 && (c == 2 || c == 3),
              fin && (c == 4 || (c == 1 && !acked))};
   endfunction
   task automatic step(input int i);
      if (!rst_n) begin
         m_busy[i] = 1'b0;
         m_ret[i] = 32'd0;
      end else if (m_busy[i]) begin
         if (m_k[i] == last_cyc(i)) begin
            m_busy[i] = 1'b0;
            if (m_cls[i] != 4 && !(m_cls[i] == 1 && m_ack[i] == 0)) m_ret[i] = m_ret[i] + 32'd1;
         end else begin
            if (m_cls[i] == 1 && m_ack[i] == 0 && m_k[i] >= 3 && mem_ack) m_ack[i] = m_k[i];
            m_k[i] = m_k[i] + 1;
         end
      end else if (instr_valid) begin
         m_busy[i] = 1'b1;
         m_k[i] = 1;
         m_cls[i] = cls_of(i, int'(opcode));
         m_ack[i] = 0;
      end
   endtask
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      for (int i = 0; i < 2; i++) step(i);
      if (!rst_n) m_on = 1'b1;
      #1;
   endtask
   task automatic issue(input int op);
      instr_valid = 1'b1;
      opcode = 4'(op);
      cyc();
      instr_valid = 1'b0;
   endtask
   always @(negedge clk) begin
      if (m_on) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d_outputs", i), i == 0 ? dv0 : dv1, exp_vec(i));
            chk($sformatf("dut%0d_retired", i), i == 0 ? rc0 : rc1, PERF ? m_ret[i] : 32'd0);
         end
      end
   end
   initial begin
      int mq, m0, m1, e0, e1, e1_at;
      bit acc;
      int ack_pct;
      rst_n = 1'b0; instr_valid = 1'b1; opcode = 4'd3; mem_ack = 1'b1;
      repeat (2) begin
         cyc();
         chk("rst_dut0", dv0, 32'h200);
         chk("rst_dut1", dv1, 32'h200);
         chk("rst_cnt", rc0, 0);
      end
      rst_n = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
      cyc();
      issue(3);
      chk("r_t1_busy", dv0[8], 1); chk("r_t1_alu", dv0[7], 0);
      cyc(); chk("r_t2_alu", dv0[7], 1); chk("r_t2_imm", dv0[6], 0);
      cyc(); chk("r_t3_wr", dv0[2], 1);
      cyc(); chk("r_t4_rdy", dv0[9], 1);
      issue(10);
      chk("i_t1_imm", dv0[6], 1);
      repeat (2) cyc();
      mq = int'(dv0[3]); cyc();
      mq += int'(dv0[3]); cyc();
      mq += int'(dv0[3]); mem_ack = 1'b1; cyc();
      mem_ack = 1'b0;
      chk("i_mreq_cycles", mq, 3); chk("i_t6_wr", dv0[2], 1);
      chk("i_t6_mreq", dv0[3], 0); chk("i_t6_imm", dv0[6], 1);
      cyc(); chk("i_t7_rdy", dv0[9], 1);
      issue(13);
      chk("b_t1_br", dv0[5], 1);
      repeat (2) cyc();
      chk("b_t3_pcl", dv0[1], 1); chk("b_t3_wr", dv0[2], 0);
      cyc(); chk("b_t4_br", dv0[5], 0);
      chk("cnt3_dut0", rc0, PERF ? 3 : 0); chk("cnt3_dut1", rc1, PERF ? 3 : 0);
      issue(15);
      chk("j_t1_jmp", dv0[4], 1); chk("ill_t1_jmp", dv1[4], 0);
      cyc(); chk("ill_t2_err", dv1[0], 1); chk("j_t2_err", dv0[0], 0);
      cyc(); chk("j_t3_pcl", dv0[1], 1); chk("ill_t3_rdy", dv1[9], 1);
      cyc();
      issue(9);
      m0 = 0; m1 = 0; e0 = 0; e1 = 0; e1_at = 0;
      for (int t = 1; t <= 21; t++) begin
         m0 += int'(dv0[3]); m1 += int'(dv1[3]);
         e0 += int'(dv0[0]); e1 += int'(dv1[0]);
         if (dv1[0]) e1_at = t;
         cyc();
      end
      chk("tmo_mreq_dut0", m0, 16); chk("tmo_mreq_dut1", m1, 4);
      chk("tmo_err_dut0", e0, 1); chk("tmo_err_dut1", e1, 1); chk("tmo_err_at_dut1", e1_at, 7);
      mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
      chk("late_ack_busy0", dv0[8], 0); chk("late_ack_busy1", dv1[8], 0);
      cyc();
      issue(10);
      repeat (3) cyc();
      chk("mid_mem_req", dv0[3], 1); chk("pre_rst_cnt", rc0, PERF ? 4 : 0);
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      chk("rst_mem_req", dv0[3], 0); chk("rst_rdy", dv0[9], 1);
      chk("rst_cnt0", rc0, 0); chk("rst_cnt1", rc1, 0);
      acc = 1'b0; ack_pct = 0;
      for (int c = 0; c < 4000; c++) begin
         if (!instr_valid || acc) begin
            instr_valid = $urandom_range(0, 3) != 0;
            opcode = 4'($urandom_range(0, 15));
            ack_pct = int'($urandom_range(0, 2)) * 30;
         end
         mem_ack = int'($urandom_range(0, 99)) < ack_pct;
         rst_n = $urandom_range(0, 799) != 0;
         acc = instr_valid && (dv0[9] || dv1[9]);
         cyc();
      end
      rst_n = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
      repeat (25) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
